// File: rtl/peaxi4_slave_mem.sv
// rtl/peaxi4_slave_mem.sv - AXI4 slave responder backed by a word-addressed on-chip memory
// Independent write (AW/W/B) and read (AR/R) state machines; INCR/FIXED bursts up to 256 beats.
module peaxi4_slave_mem #(
  parameter int          MEM_DEPTH = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_awaddr,
  input  logic [7:0]  s_awlen,
  input  logic [2:0]  s_awsize,
  input  logic [1:0]  s_awburst,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wlast,
  input  logic        s_wvalid,
  output logic        s_wready,
  output logic [1:0]  s_bresp,
  output logic        s_bvalid,
  input  logic        s_bready,
  input  logic [31:0] s_araddr,
  input  logic [7:0]  s_arlen,
  input  logic [2:0]  s_arsize,
  input  logic [1:0]  s_arburst,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rlast,
  output logic        s_rvalid,
  input  logic        s_rready
);

  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic       R_IDLE = 1'b0;
  localparam logic       R_DATA = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [31:0] mem [MEM_DEPTH];

  function automatic logic addr_bad(input logic [31:0] a);
    return (a < BASE_ADDR) || (((a - BASE_ADDR) >> 2) >= 32'(MEM_DEPTH));
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
    return IW'((a - BASE_ADDR) >> 2);
  endfunction

  // Only size 4 bytes and INCR/FIXED are served; WRAP and reserved both have burst[1] set
  function automatic logic burst_unsupported(input logic [2:0] size, input logic [1:0] burst);
    return (size != 3'b010) || burst[1];
  endfunction

  logic [1:0]  w_state;
  logic [31:0] w_addr;
  logic [7:0]  w_len;
  logic [7:0]  w_cnt;
  logic        w_incr;
  logic        w_burst_err;
  logic        w_resp_err;
  logic        w_fire;
  logic        w_beat_bad;
  logic        w_beat_last;

  assign s_awready   = !rst && (w_state == W_IDLE);
  assign s_wready    = !rst && (w_state == W_DATA);
  assign s_bvalid    = !rst && (w_state == W_RESP);
  assign s_bresp     = (s_bvalid && w_resp_err) ? RESP_SLVERR : RESP_OKAY;
  assign w_fire      = s_wvalid && s_wready;
  assign w_beat_bad  = addr_bad(w_addr);
  assign w_beat_last = (w_cnt == w_len);

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state     <= W_IDLE;
      w_addr      <= '0;
      w_len       <= '0;
      w_cnt       <= '0;
      w_incr      <= 1'b0;
      w_burst_err <= 1'b0;
      w_resp_err  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (s_awvalid) begin
          w_addr      <= s_awaddr;
          w_len       <= s_awlen;
          w_cnt       <= '0;
          w_incr      <= (s_awburst == 2'b01);
          w_burst_err <= burst_unsupported(s_awsize, s_awburst);
          w_resp_err  <= burst_unsupported(s_awsize, s_awburst);
          w_state     <= W_DATA;
        end
        W_DATA: if (w_fire) begin
          w_cnt <= w_cnt + 8'd1;
          if (w_incr) w_addr <= w_addr + 32'd4;
          // Burst length comes from awlen alone; a misplaced wlast only poisons the response
          if (w_beat_bad || (s_wlast != w_beat_last)) w_resp_err <= 1'b1;
          if (w_beat_last) w_state <= W_RESP;
        end
        W_RESP: if (s_bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire && !w_burst_err && !w_beat_bad) begin
      for (int i = 0; i < 4; i++) begin
        if (s_wstrb[i]) mem[word_idx(w_addr)][8*i +: 8] <= s_wdata[8*i +: 8];
      end
    end
  end

  logic        r_state;
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [7:0]  r_cnt;
  logic        r_incr;
  logic        r_burst_err;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        rlast_q;
  logic [31:0] r_load_addr;
  logic        r_load_err;
  logic [7:0]  r_cnt_next;

  assign s_arready  = !rst && (r_state == R_IDLE);
  assign s_rvalid   = !rst && (r_state == R_DATA);
  assign s_rdata    = s_rvalid ? rdata_q : 32'd0;
  assign s_rresp    = s_rvalid ? rresp_q : RESP_OKAY;
  assign s_rlast    = s_rvalid && rlast_q;
  assign r_cnt_next = r_cnt + 8'd1;

  // Address of the beat loaded this cycle: beat 0 from AR, otherwise the successor of the current beat
  always_comb begin
    r_load_addr = s_araddr;
    r_load_err  = burst_unsupported(s_arsize, s_arburst);
    if (r_state == R_DATA) begin
      r_load_addr = r_incr ? (r_addr + 32'd4) : r_addr;
      r_load_err  = r_burst_err;
    end
    r_load_err = r_load_err || addr_bad(r_load_addr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= R_IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_incr      <= 1'b0;
      r_burst_err <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= RESP_OKAY;
      rlast_q     <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (s_arvalid) begin
          r_addr      <= s_araddr;
          r_len       <= s_arlen;
          r_cnt       <= '0;
          r_incr      <= (s_arburst == 2'b01);
          r_burst_err <= burst_unsupported(s_arsize, s_arburst);
          rdata_q     <= r_load_err ? 32'd0 : mem[word_idx(r_load_addr)];
          rresp_q     <= r_load_err ? RESP_SLVERR : RESP_OKAY;
          rlast_q     <= (s_arlen == 8'd0);
          r_state     <= R_DATA;
        end
        R_DATA: if (s_rready) begin
          if (rlast_q) begin
            r_state <= R_IDLE;
          end else begin
            r_addr  <= r_load_addr;
            r_cnt   <= r_cnt_next;
            rdata_q <= r_load_err ? 32'd0 : mem[word_idx(r_load_addr)];
            rresp_q <= r_load_err ? RESP_SLVERR : RESP_OKAY;
            rlast_q <= (r_cnt_next == r_len);
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peaxi4_slave_mem.sv
// tb/tb_peaxi4_slave_mem.sv - self-checking bench for peaxi4_slave_mem
// Directed and randomized AXI4 bursts checked against an array model of the memory.
module tb_peaxi4_slave_mem;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_awaddr;
  logic [7:0]  s_awlen;
  logic [2:0]  s_awsize;
  logic [1:0]  s_awburst;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wlast;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [31:0] s_araddr;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic        s_rvalid;
  logic        s_rready;

  peaxi4_slave_mem #(.MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  always #5 clk = ~clk;

  logic [31:0] model [DEPTH];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic beat_bad(input logic [31:0] a);
    return (a < BASE) || (((a - BASE) >> 2) >= 32'(DEPTH));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst, input int b);
    return (burst == 2'b01) ? a + 32'(4 * b) : a;
  endfunction

  function automatic logic bad_burst(input logic [2:0] size, input logic [1:0] burst);
    return (size != 3'b010) || (burst >= 2'b10);
  endfunction

  task automatic apply_beat(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++)
      if (s[i]) model[widx(a)][8*i +: 8] = d[8*i +: 8];
  endtask

  // wlast_mode: 0 correct, 1 asserted on beat 0 (early), 2 never asserted
  task automatic do_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                          input logic [1:0] burst, input int wlast_mode, input int bdelay);
    logic berr, err, wl;
    logic [31:0] a;
    int t;
    berr = bad_burst(size, burst);
    err  = berr;
    s_awaddr = addr; s_awlen = 8'(len); s_awsize = size; s_awburst = burst; s_awvalid = 1'b1;
    t = 0;
    while (!s_awready && t < 50) begin tick(); t++; end
    check("aw_ready", 32'(s_awready), 32'd1);
    tick();
    s_awvalid = 1'b0;
    check("aw_ready_drop", 32'(s_awready), 32'd0);
    check("w_ready_first", 32'(s_wready), 32'd1);
    for (int b = 0; b <= len; b++) begin
      wl = (wlast_mode == 0) ? (b == len) : (wlast_mode == 1) ? (b == 0) : 1'b0;
      s_wdata = wd[b]; s_wstrb = ws[b]; s_wlast = wl; s_wvalid = 1'b1;
      if (wl != (b == len)) err = 1'b1;
      a = beat_addr(addr, burst, b);
      if (beat_bad(a)) err = 1'b1;
      else if (!berr) apply_beat(a, wd[b], ws[b]);
      tick();
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    check("b_valid", 32'(s_bvalid), 32'd1);
    check("b_resp", 32'(s_bresp), err ? 32'd2 : 32'd0);
    for (int i = 0; i < bdelay; i++) begin
      tick();
      check("b_valid_hold", 32'(s_bvalid), 32'd1);
      check("b_resp_hold", 32'(s_bresp), err ? 32'd2 : 32'd0);
      check("aw_blocked", 32'(s_awready), 32'd0);
    end
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
    check("b_valid_drop", 32'(s_bvalid), 32'd0);
    check("aw_ready_again", 32'(s_awready), 32'd1);
  endtask

  // stall_mode: 0 rready always high, 1 random stalls, 2 pattern 1-0-0-1 around beat 1
  task automatic do_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                         input logic [1:0] burst, input int stall_mode);
    logic berr;
    logic [31:0] a, exp_d;
    logic [1:0]  exp_r;
    int t, nst;
    berr = bad_burst(size, burst);
    s_araddr = addr; s_arlen = 8'(len); s_arsize = size; s_arburst = burst; s_arvalid = 1'b1;
    t = 0;
    while (!s_arready && t < 50) begin tick(); t++; end
    check("ar_ready", 32'(s_arready), 32'd1);
    tick();
    s_arvalid = 1'b0;
    check("ar_ready_drop", 32'(s_arready), 32'd0);
    check("r_valid_first", 32'(s_rvalid), 32'd1);
    for (int b = 0; b <= len; b++) begin
      a = beat_addr(addr, burst, b);
      if (berr || beat_bad(a)) begin exp_d = 32'd0; exp_r = 2'b10; end
      else begin exp_d = model[widx(a)]; exp_r = 2'b00; end
      nst = (stall_mode == 1) ? int'($urandom_range(0, 2)) : (stall_mode == 2 && b == 1) ? 2 : 0;
      for (int s = 0; s < nst; s++) begin
        s_rready = 1'b0;
        check("r_data_stall", s_rdata, exp_d);
        check("r_last_stall", 32'(s_rlast), 32'(b == len));
        tick();
      end
      s_rready = 1'b1;
      check("r_valid", 32'(s_rvalid), 32'd1);
      check("r_data", s_rdata, exp_d);
      check("r_resp", 32'(s_rresp), 32'(exp_r));
      check("r_last", 32'(s_rlast), 32'(b == len));
      tick();
      s_rready = 1'b0;
    end
    check("r_valid_drop", 32'(s_rvalid), 32'd0);
    check("ar_ready_again", 32'(s_arready), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awready"}, 32'(s_awready), 32'd0);
    check({tag, "_wready"},  32'(s_wready),  32'd0);
    check({tag, "_bvalid"},  32'(s_bvalid),  32'd0);
    check({tag, "_bresp"},   32'(s_bresp),   32'd0);
    check({tag, "_arready"}, 32'(s_arready), 32'd0);
    check({tag, "_rvalid"},  32'(s_rvalid),  32'd0);
    check({tag, "_rdata"},   s_rdata,        32'd0);
    check({tag, "_rresp"},   32'(s_rresp),   32'd0);
    check({tag, "_rlast"},   32'(s_rlast),   32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old_v, new_v;
    int w;
    int len;
    logic [1:0] burst;

    rst = 1'b1;
    s_awaddr = '0; s_awlen = '0; s_awsize = 3'b010; s_awburst = 2'b01; s_awvalid = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
    s_araddr = '0; s_arlen = '0; s_arsize = 3'b010; s_arburst = 2'b01; s_arvalid = 1'b0;
    s_rready = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check("idle_awready", 32'(s_awready), 32'd1);
    check("idle_arready", 32'(s_arready), 32'd1);

    // Fill the whole memory with known data using maximal 256-beat bursts
    for (int k = 0; k < DEPTH / 256; k++) begin
      for (int b = 0; b < 256; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
      do_write(BASE + 32'(k * 1024), 255, 3'b010, 2'b01, 0, 0);
    end

    // Single beat
    wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
    do_write(32'h10, 0, 3'b010, 2'b01, 0, 0);
    do_read(32'h10, 0, 3'b010, 2'b01, 0);

    // INCR with partial strobe over all-ones
    for (int b = 0; b < 4; b++) begin wd[b] = 32'hFFFF_FFFF; ws[b] = 4'hF; end
    do_write(32'h40, 3, 3'b010, 2'b01, 0, 0);
    for (int b = 0; b < 4; b++) begin wd[b] = 32'(b + 1); ws[b] = (b == 2) ? 4'b0011 : 4'hF; end
    do_write(32'h40, 3, 3'b010, 2'b01, 0, 0);
    check("incr_model_beat2", model[widx(32'h48)], 32'hFFFF_0003);
    do_read(32'h40, 3, 3'b010, 2'b01, 0);

    // Crossing the top of memory
    wd[0] = 32'hA5A5_0001; wd[1] = 32'hA5A5_0002; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(BASE + 32'(4 * (DEPTH - 1)), 1, 3'b010, 2'b01, 0, 0);
    do_read(BASE + 32'(4 * (DEPTH - 1)), 1, 3'b010, 2'b01, 0);

    // Unsupported size / burst type
    do_read(32'h40, 3, 3'b011, 2'b01, 0);
    do_read(32'h40, 3, 3'b010, 2'b10, 0);
    wd[0] = 32'h1234_5678; ws[0] = 4'hF;
    do_write(32'h80, 0, 3'b001, 2'b01, 0, 0);
    do_read(32'h80, 0, 3'b010, 2'b01, 0);

    // wlast early / missing: data still written, response SLVERR
    for (int b = 0; b < 3; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
    do_write(32'h100, 2, 3'b010, 2'b01, 1, 0);
    for (int b = 0; b < 3; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
    do_write(32'h110, 2, 3'b010, 2'b01, 2, 0);
    do_read(32'h100, 7, 3'b010, 2'b01, 0);

    // Backpressure on B and R
    for (int b = 0; b < 4; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
    do_write(32'h180, 3, 3'b010, 2'b01, 0, 5);
    do_read(32'h180, 7, 3'b010, 2'b01, 2);

    // FIXED burst: last beat wins
    for (int b = 0; b < 4; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
    do_write(32'h1C0, 3, 3'b010, 2'b00, 0, 0);
    do_read(32'h1C0, 3, 3'b010, 2'b00, 0);

    // Simultaneous AW and AR handshakes on the same word
    old_v = model[widx(32'h300)];
    new_v = $urandom;
    s_awaddr = 32'h300; s_awlen = 8'd0; s_awsize = 3'b010; s_awburst = 2'b01; s_awvalid = 1'b1;
    s_araddr = 32'h300; s_arlen = 8'd0; s_arsize = 3'b010; s_arburst = 2'b01; s_arvalid = 1'b1;
    check("sim_awready", 32'(s_awready), 32'd1);
    check("sim_arready", 32'(s_arready), 32'd1);
    tick();
    s_awvalid = 1'b0; s_arvalid = 1'b0;
    check("sim_rvalid", 32'(s_rvalid), 32'd1);
    check("sim_wready", 32'(s_wready), 32'd1);
    s_wdata = new_v; s_wstrb = 4'hF; s_wlast = 1'b1; s_wvalid = 1'b1;
    tick();
    s_wvalid = 1'b0; s_wlast = 1'b0;
    model[widx(32'h300)] = new_v;
    check("sim_rdata_old", s_rdata, old_v);
    check("sim_bvalid", 32'(s_bvalid), 32'd1);
    s_rready = 1'b1; s_bready = 1'b1;
    tick();
    s_rready = 1'b0; s_bready = 1'b0;

    // Read load in the same cycle as a write to the same word
    old_v = model[widx(32'h200)];
    new_v = $urandom;
    s_awaddr = 32'h200; s_awvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    s_wdata = new_v; s_wstrb = 4'hF; s_wlast = 1'b1; s_wvalid = 1'b1;
    s_araddr = 32'h200; s_arlen = 8'd0; s_arburst = 2'b01; s_arvalid = 1'b1;
    check("col_wready", 32'(s_wready), 32'd1);
    check("col_arready", 32'(s_arready), 32'd1);
    tick();
    s_wvalid = 1'b0; s_wlast = 1'b0; s_arvalid = 1'b0;
    model[widx(32'h200)] = new_v;
    check("col_rdata_old", s_rdata, old_v);
    s_rready = 1'b1; s_bready = 1'b1;
    tick();
    s_rready = 1'b0; s_bready = 1'b0;
    do_read(32'h200, 0, 3'b010, 2'b01, 0);

    // Reset during beat 2 of an 8-beat write
    s_awaddr = 32'h500; s_awlen = 8'd7; s_awsize = 3'b010; s_awburst = 2'b01; s_awvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      s_wdata = $urandom; s_wstrb = 4'hF; s_wvalid = 1'b1;
      apply_beat(32'h500 + 32'(4 * b), s_wdata, 4'hF);
      tick();
    end
    s_wdata = $urandom; rst = 1'b1;
    tick();
    check_all_zero("midrst");
    s_wvalid = 1'b0; rst = 1'b0;
    tick();
    check("post_rst_awready", 32'(s_awready), 32'd1);
    check("post_rst_arready", 32'(s_arready), 32'd1);
    check("post_rst_bvalid", 32'(s_bvalid), 32'd0);
    check("post_rst_rvalid", 32'(s_rvalid), 32'd0);
    do_read(32'h500, 7, 3'b010, 2'b01, 0);
    for (int b = 0; b < 2; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
    do_write(32'h520, 1, 3'b010, 2'b01, 0, 0);
    do_read(32'h520, 1, 3'b010, 2'b01, 0);

    // Randomized bursts
    for (int it = 0; it < 24; it++) begin
      w = int'($urandom_range(0, DEPTH - 1));
      if (it % 4 == 0) w = DEPTH - int'($urandom_range(1, 4));
      len = int'($urandom_range(0, 15));
      burst = ($urandom_range(0, 9) == 0) ? 2'(2 + $urandom_range(0, 1)) : 2'($urandom_range(0, 1));
      for (int b = 0; b <= len; b++) begin wd[b] = $urandom; ws[b] = 4'($urandom); end
      do_write(BASE + 32'(4 * w), len, 3'b010, burst, 0, int'($urandom_range(0, 3)));
      do_read(BASE + 32'(4 * w), len, 3'b010, 2'($urandom_range(0, 1)), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
